// File: rtl/keypad_pkg.sv
// keypad_pkg: shared keypad geometry, scanner states and column rotate helper
package keypad_pkg;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam logic [3:0] COL_IDLE_N = 4'b1111;
  typedef logic [1:0] state_t;
  localparam state_t SCAN     = 2'd0;
  localparam state_t DEBOUNCE = 2'd1;
  localparam state_t HELD     = 2'd2;
  function automatic logic [COLS-1:0] rotl(input logic [COLS-1:0] v);
    return {v[COLS-2:0], v[COLS-1]};
  endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: free-running divider, one-cycle tick every SCAN_DIV clocks
module scan_tick_gen #(
  parameter int SCAN_DIV = 250000
) (
  input  logic clock,
  input  logic reset_n,
  output logic tick
);
  localparam int W = $clog2(SCAN_DIV);
  logic [W-1:0] count;
  assign tick = count == W'(SCAN_DIV - 1);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) count <= '0;
    else count <= tick ? '0 : count + 1'b1;
  end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad column driver, row debouncer and key-code strobe
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 250000,
  parameter int STABLE_TICKS = 3
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [ROWS-1:0] row_n,
  output logic [COLS-1:0] col_n,
  output logic [3:0]      key_code,
  output logic            key_valid,
  output logic            key_held
);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);
  logic [ROWS-1:0] row_meta, rows_s;
  logic tick, rows_idle;
  logic [1:0] col, cand_row, sel_row;
  logic [CW-1:0] streak;
  state_t state;
  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (.clock(clock), .reset_n(reset_n), .tick(tick));
  always_comb begin
    rows_idle = rows_s == COL_IDLE_N;
    sel_row = !rows_s[0] ? 2'd0 : !rows_s[1] ? 2'd1 : !rows_s[2] ? 2'd2 : 2'd3;
  end
  // streak counts matching ticks in DEBOUNCE and idle ticks in HELD
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_meta  <= COL_IDLE_N;
      rows_s    <= COL_IDLE_N;
      col_n     <= 4'b1110;
      col       <= '0;
      cand_row  <= '0;
      streak    <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      state     <= SCAN;
    end else begin
      row_meta  <= row_n;
      rows_s    <= row_meta;
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN:
            if (rows_idle) begin
              col   <= col + 2'd1;
              col_n <= rotl(col_n);
            end else begin
              cand_row <= sel_row;
              streak   <= '0;
              state    <= DEBOUNCE;
            end
          DEBOUNCE:
            if (!rows_idle && sel_row == cand_row) begin
              if (streak == LAST) begin
                key_code  <= {cand_row, col};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                streak    <= '0;
                state     <= HELD;
              end else streak <= streak + 1'b1;
            end else state <= SCAN;
          HELD:
            if (!rows_idle) streak <= '0;
            else if (streak == LAST) begin
              key_held <= 1'b0;
              col      <= col + 2'd1;
              col_n    <= rotl(col_n);
              state    <= SCAN;
            end else streak <= streak + 1'b1;
          default: state <= SCAN;
        endcase
      end
    end
  end
endmodule
